// File: rtl/serial_mouse.sv
// ---------------------------------------------------------------------------
// serial_mouse
//   Device side of a Microsoft-compatible serial mouse. It accumulates motion
//   deltas and button states from the input front-end and sends 3-byte
//   packets at 7N1 towards the uart rx pin. When the host asserts RTS, the
//   mouse identifies itself with 'M' (0x4D) after ID_DELAY clocks. When the
//   host releases RTS, the mouse aborts any frame and powers down.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   rts_n      host RTS (active-low), asynchronous, synchronised here
//   mv_strobe  one-cycle pulse; mv_dx/mv_dy/btn_* valid
//   mv_dx      signed X delta, +right
//   mv_dy      signed Y delta, +down
//   btn_l      left button pressed
//   btn_r      right button pressed
//   tx         serial data, idle high
//   busy       byte frame in progress
// ---------------------------------------------------------------------------
module serial_mouse #(
   parameter int BAUD_DIV = 11932,
   parameter int ID_DELAY = 107388
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rts_n,
   input  logic       mv_strobe,
   input  logic [8:0] mv_dx,
   input  logic [8:0] mv_dy,
   input  logic       btn_l,
   input  logic       btn_r,
   output logic       tx,
   output logic       busy
);

   localparam int BAUD_W = $clog2(BAUD_DIV + 1);
   localparam int ID_W   = $clog2(ID_DELAY + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(ID_DELAY - 1);

   typedef enum logic [2:0] {
      S_OFF, S_ID_WAIT, S_ID_TX, S_IDLE, S_TX_B1, S_TX_B2, S_TX_B3
   } state_t;

   state_t             state, state_nx;
   logic               rts_meta, rts_s;
   logic [ID_W-1:0]    id_cnt;
   logic [BAUD_W-1:0]  baud_cnt;
   logic [3:0]         bit_cnt;
   logic [8:0]         shreg;       // {stop, data[6:0], start}, shifted out LSB first
   logic signed [9:0]  acc_x, acc_y;
   logic [1:0]         btn_lat;     // {L, R} from the last strobe
   logic [1:0]         btn_sent;    // {L, R} carried by the last packet
   logic [5:0]         x_lo, y_lo;  // low bits of the snapshot for bytes 2 and 3

   logic               byte_done, start_byte, snapshot, abort, pending;
   logic [6:0]         load_byte;
   logic [7:0]         snap_x, snap_y;
   logic signed [9:0]  base_x, base_y;

   // Clamp a 10-bit accumulator to the 8-bit packet range.
   function automatic logic [7:0] clamp8(input logic signed [9:0] a);
      if (a > 10'sd127)       return 8'h7F;
      else if (a < -10'sd128) return 8'h80;
      else                    return a[7:0];
   endfunction

   // Saturating add of a 9-bit delta into a 10-bit accumulator.
   function automatic logic signed [9:0] sat_add(input logic signed [9:0] a,
                                                 input logic signed [8:0] d);
      logic signed [10:0] s;
      s = {a[9], a} + {{2{d[8]}}, d};
      if (s > 11'sd511)       return 10'sd511;
      else if (s < -11'sd512) return -10'sd512;
      else                    return s[9:0];
   endfunction

   assign tx        = shreg[0];
   assign byte_done = busy && (baud_cnt == BAUD_LAST) && (bit_cnt == 4'd8);
   assign abort     = (state != S_OFF) && rts_s;
   assign pending   = (acc_x != 10'sd0) || (acc_y != 10'sd0) || (btn_lat != btn_sent);
   assign snap_x    = clamp8(acc_x);
   assign snap_y    = clamp8(acc_y);

   // Accumulator after the snapshot is removed; a coinciding strobe adds on top.
   assign base_x = snapshot ? acc_x - {{2{snap_x[7]}}, snap_x} : acc_x;
   assign base_y = snapshot ? acc_y - {{2{snap_y[7]}}, snap_y} : acc_y;

   // NOTE: every always_ff below uses non-blocking assignments so all flops
   // update together from values sampled at the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rts_meta <= 1'b1;
         rts_s    <= 1'b1;
         state    <= S_OFF;
      end else begin
         rts_meta <= rts_n;
         rts_s    <= rts_meta;
         state    <= state_nx;
      end
   end

   // NOTE: all outputs of this block get a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nx   = state;
      start_byte = 1'b0;
      snapshot   = 1'b0;
      load_byte  = 7'h00;
      if (abort) begin
         state_nx = S_OFF;
      end else begin
         case (state)
            S_OFF:     if (!rts_s) state_nx = S_ID_WAIT;
            S_ID_WAIT: if (id_cnt == ID_LAST) begin
                          state_nx   = S_ID_TX;
                          start_byte = 1'b1;
                          load_byte  = 7'h4D;
                       end
            S_ID_TX:   if (byte_done) state_nx = S_IDLE;
            S_IDLE:    if (pending) begin
                          state_nx   = S_TX_B1;
                          start_byte = 1'b1;
                          snapshot   = 1'b1;
                          load_byte  = {1'b1, btn_lat, snap_y[7:6], snap_x[7:6]};
                       end
            S_TX_B1:   if (byte_done) begin
                          state_nx   = S_TX_B2;
                          start_byte = 1'b1;
                          load_byte  = {1'b0, x_lo};
                       end
            S_TX_B2:   if (byte_done) begin
                          state_nx   = S_TX_B3;
                          start_byte = 1'b1;
                          load_byte  = {1'b0, y_lo};
                       end
            S_TX_B3:   if (byte_done) state_nx = S_IDLE;
            default:   state_nx = S_OFF;
         endcase
      end
   end

   // Identification delay counter, running only while waiting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                           id_cnt <= '0;
      else if (state == S_ID_WAIT && !abort)  id_cnt <= id_cnt + ID_W'(1);
      else                                    id_cnt <= '0;
   end

   // Byte serialiser. A new byte loaded on the last stop-bit clock follows
   // the previous one with no idle gap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg    <= '1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         busy     <= 1'b0;
      end else if (abort || state == S_OFF) begin
         shreg    <= '1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         busy     <= 1'b0;
      end else if (start_byte) begin
         shreg    <= {1'b1, load_byte, 1'b0};
         baud_cnt <= '0;
         bit_cnt  <= '0;
         busy     <= 1'b1;
      end else if (busy) begin
         if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd8) begin
               busy <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               shreg   <= {1'b1, shreg[8:1]};
            end
         end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
         end
      end
   end

   // Motion accumulators and button tracking. Held clear while powered down
   // or waiting to identify, so nothing stale follows the 'M'.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_x    <= '0;
         acc_y    <= '0;
         btn_lat  <= '0;
         btn_sent <= '0;
         x_lo     <= '0;
         y_lo     <= '0;
      end else if (abort || state == S_OFF || state == S_ID_WAIT) begin
         acc_x    <= '0;
         acc_y    <= '0;
         btn_lat  <= '0;
         btn_sent <= '0;
      end else begin
         acc_x <= mv_strobe ? sat_add(base_x, mv_dx) : base_x;
         acc_y <= mv_strobe ? sat_add(base_y, mv_dy) : base_y;
         if (mv_strobe) btn_lat <= {btn_l, btn_r};
         if (snapshot) begin
            btn_sent <= btn_lat;
            x_lo     <= snap_x[5:0];
            y_lo     <= snap_y[5:0];
         end
      end
   end

endmodule

// File: doc/serial_mouse.md
Name: serial_mouse

Overview:
- Device-side Microsoft-compatible serial mouse. Drives the `rx` input of the `uart` (16550) block, so it is the far end of the COM-port link.
- Accepts movement deltas and button states from the input front-end (PS/2 decoder or OSD), accumulates them, and serialises 3-byte packets at 7N1.
- Powers up and identifies itself with 'M' (0x4D) when the host asserts RTS, as MS-DOS mouse drivers expect.

Parameters:
- BAUD_DIV, 11932, clk cycles per bit period (14.318 MHz / 1200 baud).
- ID_DELAY, 107388, clk cycles from RTS assertion to start of the 'M' byte.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rts_n  in  1  host RTS from `uart` (active-low); asynchronous, double-flop synchronised internally
- mv_strobe  in  1  one-cycle pulse; mv_dx/mv_dy/btn_* valid
- mv_dx  in  9  signed X delta, +right
- mv_dy  in  9  signed Y delta, +down (screen convention)
- btn_l  in  1  left button pressed
- btn_r  in  1  right button pressed
- tx  out  1  serial data to `uart` rx; idle high
- busy  out  1  byte frame in progress

Behaviour:
- Reset values: tx=1, busy=0, state=OFF, accumulators=0, last-sent buttons=0, latched buttons=0, sync flops=1.
- Frame format:
  - start bit (0), 7 data bits LSB first, stop bit (1): 9 bit periods of exactly BAUD_DIV clocks each.
  - Consecutive bytes of one packet are back to back, with no gap.
  - busy=1 from the first start-bit clock to the last stop-bit clock.
- Packet format, with X and Y the clamped 8-bit values:
  - byte1 = {1, L, R, Y[7:6], X[7:6]}
  - byte2 = {0, X[5:0]}
  - byte3 = {0, Y[5:0]}
- Accumulators:
  - accX and accY are 10-bit signed, saturating at -512..511.
  - On mv_strobe: acc += sign-extended delta (saturating), and the buttons are latched.
- State machine (`rts_s` = synchronised rts_n):
  - OFF: tx=1, accumulators cleared. Go to ID_WAIT when rts_s=0. This is level-triggered, so it also covers release from reset with RTS already asserted.
  - ID_WAIT: count ID_DELAY clocks, then go to ID_TX. Strobes are ignored; accumulators are held at 0.
  - ID_TX: send 0x4D, then go to IDLE.
  - IDLE: start a packet when accX≠0, accY≠0, or latched buttons ≠ last-sent buttons.
- Packet snapshot, taken in the clock the packet starts:
  - X = clamp(accX, -128..127), Y likewise.
  - accX -= X and accY -= Y; the residual carries into later packets.
  - last-sent buttons = latched buttons.
  - Then go TX_B1 → TX_B2 → TX_B3 → IDLE.
- Strobe coinciding with the snapshot: the new delta is added to the post-subtraction accumulator, so no motion is lost.
- Strobes during transmission are accumulated; button changes during transmission are reflected in the next packet.
- Power-down:
  - From any state other than OFF, rts_s=1 means go to OFF immediately.
  - tx=1 no later than 3 clocks after the rts_n rising edge; a partial frame is aborted.
  - busy=0 and accumulators are cleared, so no stale packet is sent after re-identification.
- Baud counter and bit counter restart from zero at the start of each byte. No fractional baud accumulation is performed.
- Assertion of reset_n low at any time: all state returns to reset values asynchronously.

Test Plan:
All scenarios run with BAUD_DIV=4 and ID_DELAY=36.
- Release reset with rts_n=0 → after sync plus 36 clocks, tx carries 0,1,0,1,1,0,0,1,1, each bit 4 clocks (0x4D); then tx stays high and busy=0.
- After ID, strobe dx=+5, dy=-3, btn_l=1 → bytes 0x6C, 0x05, 0x3D back to back (27 bit periods); accumulators then 0.
- Strobe dx=+200, dy=0 → packet 0x41, 0x3F, 0x00 (X=127), immediately followed by 0x41, 0x09, 0x00 (X=73).
- With button L last sent, strobe btn_l=0 and dx=dy=0 → packet 0x40, 0x00, 0x00; no further packets.
- Deassert rts_n mid-byte2 → tx=1 within 3 clocks, busy=0. Reassert → 'M' only; no residual packet.
- Two strobes dx=+10 then +20 while a packet is in flight → next packet carries X=30: bytes 0x40, 0x1E, 0x00.
